// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver with mid-bit sampling and valid/ready word output
module serial_frame_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clock,
    input  logic              i_rst_n,
    input  logic              i_data,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_frame_err,
    output logic              o_overrun
);

    localparam int H     = CLKS_PER_BIT / 2;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state;
    logic              sync1;
    logic              sync2;
    logic              prev;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shreg;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle level is high
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= i_data;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Frame FSM: mid-bit sampling, LSB-first assembly, output handshake and status pulses
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;

            // Consumer take; a word completing on the same edge overrides this below
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    // Only a high-to-low transition starts a frame, so a line held low is ignored
                    if (!sync2 && prev) begin
                        state  <= S_START;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= '0;
                        if (!sync2) begin
                            state <= S_DATA;
                        end else begin
                            // Line back high at mid start bit: treat as a glitch
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt              <= '0;
                        idx              <= idx + 1'b1;
                        shreg[DATA_W-1]  <= sync2;
                        for (int i = 0; i < DATA_W - 1; i++) begin
                            shreg[i] <= shreg[i+1];
                        end
                        if (idx == IDX_LAST) begin
                            state <= S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt    <= '0;
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        if (!sync2) begin
                            o_frame_err <= 1'b1;
                        end else if (!o_valid || i_ready) begin
                            o_data  <= shreg;
                            o_valid <= 1'b1;
                        end else begin
                            o_overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - directed and randomized checks of serial_frame_rx against a frame-level model
module tb_serial_frame_rx;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;

    logic       clock;
    logic       i_rst_n;
    logic       i_data;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs after the most recent edge
    logic       exp_valid;
    logic       exp_busy;
    logic       exp_err;
    logic       exp_ovr;
    logic [7:0] exp_data;

    // Words actually handed over to the consumer
    logic [7:0] got_q[$];

    serial_frame_rx #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock      (clock),
        .i_rst_n    (i_rst_n),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Record every handshake the consumer completes
    always @(posedge clock) begin
        if (o_valid && i_ready) got_q.push_back(o_data);
    end

    task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check_vec({tag, ".valid"}, {15'd0, o_valid}, {15'd0, exp_valid});
        check_vec({tag, ".data"}, {8'd0, o_data}, {8'd0, exp_data});
        check_vec({tag, ".busy"}, {15'd0, o_busy}, {15'd0, exp_busy});
        check_vec({tag, ".frame_err"}, {15'd0, o_frame_err}, {15'd0, exp_err});
        check_vec({tag, ".overrun"}, {15'd0, o_overrun}, {15'd0, exp_ovr});
    endtask

    // Advance one clock edge, applying the handshake rules to the model first
    task automatic step(input logic done, input logic [7:0] word, input logic good);
        logic was_valid;
        was_valid = exp_valid;
        exp_err   = 1'b0;
        exp_ovr   = 1'b0;
        if (exp_valid && i_ready) exp_valid = 1'b0;
        if (done) begin
            if (!good) begin
                exp_err = 1'b1;
            end else if (!was_valid || i_ready) begin
                exp_data  = word;
                exp_valid = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        i_data   = 1'b1;
        exp_busy = 1'b0;
        repeat (n) begin
            step(1'b0, 8'h00, 1'b0);
            check_all(tag);
        end
    endtask

    // Drive one frame, CPB cycles per bit; word completes on the edge after the stop bit ends
    task automatic send_frame(input string tag, input logic [7:0] w, input logic stop_bit,
                              input logic rdy_done, input int abort_at);
        int bits[10];
        int word;
        bits[0] = 0;
        for (int k = 0; k < DATA_W; k++) bits[k+1] = (int'(w) >> k) & 1;
        bits[9] = int'(stop_bit);
        word = 0;
        for (int k = 0; k < DATA_W; k++) word += bits[k+1] * (1 << k);
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c == abort_at) return;
            i_data   = (bits[c / CPB] != 0);
            exp_busy = (c >= 2);
            step(1'b0, 8'h00, 1'b0);
            check_all(tag);
        end
        i_data   = 1'b1;
        i_ready  = rdy_done;
        exp_busy = 1'b0;
        step(1'b1, word[7:0], bits[9] != 0);
        check_all({tag, ".done"});
    endtask

    initial begin
        logic [7:0] w;
        logic       sb;
        logic       rd;

        i_rst_n   = 1'b1;
        i_data    = 1'b1;
        i_ready   = 1'b0;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        exp_err   = 1'b0;
        exp_ovr   = 1'b0;
        exp_data  = 8'h00;

        // Reset state
        #2 i_rst_n = 1'b0;
        #1 check_all("reset");
        @(posedge clock);
        #1;
        check_all("reset_hold");
        i_rst_n = 1'b1;
        idle(3, "post_reset");

        // 1: single frame with consumer ready, valid for one cycle
        i_ready = 1'b1;
        send_frame("t1_a5", 8'hA5, 1'b1, 1'b1, -1);
        idle(3, "t1_after");

        // 2: three frames, each acknowledged for one cycle after arrival
        i_ready = 1'b0;
        got_q.delete();
        send_frame("t2_00", 8'h00, 1'b1, 1'b0, -1);
        i_ready = 1'b1; idle(1, "t2_ack0"); i_ready = 1'b0;
        send_frame("t2_ff", 8'hFF, 1'b1, 1'b0, -1);
        i_ready = 1'b1; idle(1, "t2_ack1"); i_ready = 1'b0;
        send_frame("t2_3c", 8'h3C, 1'b1, 1'b0, -1);
        i_ready = 1'b1; idle(1, "t2_ack2"); i_ready = 1'b0;
        check_vec("t2_count", 16'(got_q.size()), 16'd3);
        if (got_q.size() == 3) begin
            check_vec("t2_word0", {8'd0, got_q[0]}, 16'h0000);
            check_vec("t2_word1", {8'd0, got_q[1]}, 16'h00FF);
            check_vec("t2_word2", {8'd0, got_q[2]}, 16'h003C);
        end
        idle(2, "t2_after");

        // 3: stop bit low gives a frame error, then a good frame is still received
        i_ready = 1'b1;
        send_frame("t3_55_bad", 8'h55, 1'b0, 1'b1, -1);
        idle(3, "t3_gap");
        send_frame("t3_12", 8'h12, 1'b1, 1'b1, -1);
        idle(2, "t3_after");

        // 4: two-cycle low glitch on the idle line
        i_ready  = 1'b0;
        i_data   = 1'b0; exp_busy = 1'b0;
        step(1'b0, 8'h00, 1'b0); check_all("t4_c0");
        step(1'b0, 8'h00, 1'b0); check_all("t4_c1");
        i_data   = 1'b1; exp_busy = 1'b1;
        step(1'b0, 8'h00, 1'b0); check_all("t4_c2");
        step(1'b0, 8'h00, 1'b0); check_all("t4_c3");
        idle(6, "t4_after");

        // 5: overrun when the first word is never taken, then reload with ready on the completion edge
        send_frame("t5_11", 8'h11, 1'b1, 1'b0, -1);
        idle(2, "t5_hold");
        send_frame("t5_22_ovr", 8'h22, 1'b1, 1'b0, -1);
        idle(2, "t5_after_ovr");
        i_ready = 1'b1; idle(1, "t5_take"); i_ready = 1'b0;
        send_frame("t5_11b", 8'h11, 1'b1, 1'b0, -1);
        idle(2, "t5_hold2");
        send_frame("t5_22_reload", 8'h22, 1'b1, 1'b1, -1);
        i_ready = 1'b0;
        idle(2, "t5_after_reload");

        // 6: asynchronous reset in the middle of the data bits, then a clean frame
        send_frame("t6_abort", 8'h77, 1'b1, 1'b0, 20);
        #2 i_rst_n = 1'b0;
        exp_valid = 1'b0; exp_busy = 1'b0; exp_err = 1'b0; exp_ovr = 1'b0; exp_data = 8'h00;
        #1 check_all("t6_async");
        i_data = 1'b1;
        idle(2, "t6_in_reset");
        i_rst_n = 1'b1;
        idle(3, "t6_released");
        send_frame("t6_9c", 8'h9C, 1'b1, 1'b0, -1);
        i_ready = 1'b1; idle(1, "t6_take"); i_ready = 1'b0;
        idle(2, "t6_after");

        // Randomized frames, stop bits and consumer readiness
        for (int n = 0; n < 10; n++) begin
            w       = 8'($urandom);
            sb      = ($urandom % 4) != 0;
            rd      = 1'($urandom % 2);
            i_ready = 1'($urandom % 2);
            send_frame("rand", w, sb, rd, -1);
            i_ready = 1'($urandom % 2);
            idle($urandom_range(1, 3), "rand_gap");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
